anim_char_scheduler: RTL and testbench
======================================

# anim_char_scheduler

Sequences characters into the 7-segment animator at the 60 Hz tick rate. It holds a small writable message buffer and plays it back one character per hold period, optionally looping. It arbitrates the animator between the background message and a higher-priority live-character requester. Its outputs drive the animator's `charInput` and `charAvailable`.

## Interface
- `MSG_LEN`, 8: message buffer depth in characters, power of two, ≥2.
- `HOLD_TICKS`, 32: clk60 ticks a character is held before the next issue, range 2..255.
- `AW`, $clog2(MSG_LEN): derived index width, not overridden.

Ports (reset is asynchronous and active-high; clock is clk60):
- `clk60`  in  1  60 Hz tick clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `enable`  in  1  low freezes all state, counters and outputs; high runs.
- `wr_en`  in  1  write strobe for the buffer.
- `wr_addr`  in  AW  buffer write index.
- `wr_data`  in  7  segment pattern to store (bit 0 = seg a).
- `msg_last`  in  AW  index of the last character of the message.
- `start`  in  1  level, sampled per tick; starts or restarts playback at index 0.
- `loop`  in  1  when 1, playback wraps from `msg_last` to 0; when 0, playback stops after `msg_last`.
- `live_req`  in  1  level request to display `live_char`.
- `live_char`  in  7  live segment pattern.
- `live_ack`  out  1  one-tick pulse when `live_char` is issued.
- `char_out`  out  7  character presented to the animator.
- `char_valid`  out  1  one-tick issue pulse to the animator's `charAvailable`.
- `busy`  out  1  high in every state except IDLE.
- `index`  out  AW  buffer index of the current or next message character.

## Operation
- States: IDLE, ISSUE, HOLD, LIVE_HOLD. `resume` flag records whether message playback was active when a live character preempted it.
- IDLE:
  - `live_req` → issue live character (see below).
  - Otherwise `start` → `index`=0, go to ISSUE.
- ISSUE: `char_out`=buf[`index`], `char_valid`=1, hold counter=HOLD_TICKS-1, go to HOLD.
- HOLD: counter decrements each tick. When counter==0:
  - If `live_req`: issue live character with `resume`=1. `index` is unchanged, so the preempted character is reissued afterwards.
  - Else if `index`≠`msg_last`: `index`+1, go to ISSUE.
  - Else if `loop`: `index`=0, go to ISSUE.
  - Else: go to IDLE. `index` stays at `msg_last`.
- Live issue, taken from IDLE or at HOLD expiry:
  - Same tick: `char_out`=`live_char`, `char_valid`=1, `live_ack`=1, counter=HOLD_TICKS-1, go to LIVE_HOLD.
  - `resume` is set if the live issue came from HOLD, clear if from IDLE.
- LIVE_HOLD: `live_req` is ignored. When counter==0:
  - If `live_req` is still high: issue again.
  - Else if `resume`: go to ISSUE.
  - Else: go to IDLE.
- `start` in HOLD restarts playback: `index`=0, go to ISSUE next tick. `start` in LIVE_HOLD sets `resume`=1 and `index`=0. `start` in ISSUE is ignored.
- Buffer writes are accepted in every state. A write and an ISSUE read of the same address in the same tick: the old data is issued.
- `msg_last` is sampled only at HOLD expiry. Reducing it below `index` mid-play ends or wraps at the next expiry, by the same `index`≠`msg_last` rule, except that an increment past `msg_last` wraps to 0 modulo MSG_LEN.
- Reset mid-operation: all outputs and the buffer clear immediately, state goes to IDLE.

## Timing
- Reset values: `char_out`=0, `char_valid`=0, `live_ack`=0, `busy`=0, `index`=0, buffer all 0, `resume`=0.
- `start` sampled at edge N → `char_valid` high for tick N+1..N+2 with buf[0].
- Message issue period = HOLD_TICKS+1 ticks; a live-issue-to-next-issue interval is HOLD_TICKS+1 ticks as well.
- Live issue from IDLE has one-tick latency: `live_req` sampled at edge N → `char_valid` and `live_ack` high after edge N.
- All outputs are registered; no combinational path from inputs to outputs.
- `enable` low holds `char_valid` and `live_ack` low for that tick. A pending pulse is not lost: it is issued on the first enabled tick.

## Configuration
- `ANIM_SCHED_BLANK_GAP_EN` defined:
  - On a wrap (`loop`=1, `index`==`msg_last` at expiry), a blank character 7'h00 is issued first and held HOLD_TICKS+1 ticks, then buf[0] is issued.
  - `index` reads `msg_last` during the gap.
  - Wrap period becomes 2×(HOLD_TICKS+1).
- Not defined: wrap issues buf[0] directly, with no blank and no extra state.

## Structure
- Shared package `anim_pkg`:
  - state enum `sched_state_t`
  - `SEG_BLANK` = 7'h00
  - `SEG_W` = 7
  - default `HOLD_TICKS`
- Sub-module `anim_msg_buffer`: MSG_LEN×7 register file with one synchronous write port, one asynchronous read port and asynchronous clear on `reset`.

## Test plan
- Write buf[0..2] = 7'h06, 7'h5B, 7'h4F; `msg_last`=2, `loop`=0, `start` pulse → three `char_valid` pulses 33 ticks apart carrying 06, 5B, 4F; then `busy`=0, `index`=2.
- Same message with `loop`=1 → after 4F, 06 is issued 33 ticks later. With the macro defined, 00 is issued first and 06 follows 66 ticks after 4F.
- `live_req` with `live_char`=7'h3F raised mid-HOLD on `index`=1 → at expiry 3F is issued with `live_ack`; 33 ticks later 5B is reissued.
- `live_req` in IDLE held for 70 ticks → 3F issued at ticks 1, 34 and 67; then IDLE.
- `reset` asserted 10 ticks into HOLD → all outputs 0 immediately; after release, with no `start`, no `char_valid` for 100 ticks.
- `enable` low for 5 ticks spanning an expiry → next issue is delayed exactly 5 ticks, with the same character.

Source files
------------

// File: rtl/anim_pkg.sv
// Shared types and constants for the character scheduler and its message buffer.
package anim_pkg;

  localparam int SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;
  localparam int HOLD_TICKS_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_HOLD      = 2'd2,
    ST_LIVE_HOLD = 2'd3
  } sched_state_t;

endpackage

// File: rtl/anim_msg_buffer.sv
// Message buffer: MSG_LEN x SEG_W register file, one synchronous write port,
// one asynchronous read port, cleared asynchronously by reset.
module anim_msg_buffer
  import anim_pkg::*;
#(
  parameter int MSG_LEN = 8,
  parameter int AW      = $clog2(MSG_LEN)
) (
  input  logic             clk60,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [SEG_W-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [SEG_W-1:0] rd_data
);

  logic [SEG_W-1:0] mem [MSG_LEN];

  // Storage: clear on reset, otherwise take one write per tick.
  always_ff @(posedge clk60 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MSG_LEN; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read returns the contents before any same-tick write lands.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/anim_char_scheduler.sv
// Character scheduler: plays a small message buffer into the 7-segment animator
// one character per hold period, with a higher-priority live-character path.
// Optional build macro: ANIM_SCHED_BLANK_GAP_EN inserts a blank character before
// each loop wrap.
//
// state     | meaning
// IDLE      | nothing playing, waiting for live_req or start
// ISSUE     | present the selected character (message, live or blank) for one tick
// HOLD      | hold a message/blank character until the counter expires
// LIVE_HOLD | hold a live character; live_req only looked at on expiry
module anim_char_scheduler
  import anim_pkg::*;
#(
  parameter int MSG_LEN    = 8,
  parameter int HOLD_TICKS = HOLD_TICKS_DEFAULT,
  parameter int AW         = $clog2(MSG_LEN)
) (
  input  logic             clk60,
  input  logic             reset,
  input  logic             enable,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [SEG_W-1:0] wr_data,
  input  logic [AW-1:0]    msg_last,
  input  logic             start,
  input  logic             loop,
  input  logic             live_req,
  input  logic [SEG_W-1:0] live_char,
  output logic             live_ack,
  output logic [SEG_W-1:0] char_out,
  output logic             char_valid,
  output logic             busy,
  output logic [AW-1:0]    index
);

  localparam logic [1:0] S_IDLE      = ST_IDLE;
  localparam logic [1:0] S_ISSUE     = ST_ISSUE;
  localparam logic [1:0] S_HOLD      = ST_HOLD;
  localparam logic [1:0] S_LIVE_HOLD = ST_LIVE_HOLD;

  localparam logic [1:0] ISS_MSG   = 2'd0;
  localparam logic [1:0] ISS_LIVE  = 2'd1;
`ifdef ANIM_SCHED_BLANK_GAP_EN
  localparam logic [1:0] ISS_BLANK = 2'd2;
`endif

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_TICKS - 1);

  logic [1:0]       state, state_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic             resume, resume_nxt;
  logic [1:0]       iss_sel, sel_nxt;
  logic [AW-1:0]    index_nxt;
  logic [SEG_W-1:0] out_nxt;
  logic             valid_nxt, ack_nxt;
  logic [SEG_W-1:0] rd_data;
`ifdef ANIM_SCHED_BLANK_GAP_EN
  logic             in_gap, gap_nxt;
`endif

  anim_msg_buffer #(
    .MSG_LEN (MSG_LEN),
    .AW      (AW)
  ) u_buf (
    .clk60   (clk60),
    .reset   (reset),
    .wr_en   (wr_en & enable),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (index),
    .rd_data (rd_data)
  );

  // Next-state and next-output decode.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    resume_nxt = resume;
    sel_nxt    = iss_sel;
    index_nxt  = index;
    out_nxt    = char_out;
    valid_nxt  = 1'b0;
    ack_nxt    = 1'b0;
`ifdef ANIM_SCHED_BLANK_GAP_EN
    gap_nxt    = in_gap;
`endif
    case (state)
      S_IDLE: begin
        if (live_req) begin
          out_nxt    = live_char;
          valid_nxt  = 1'b1;
          ack_nxt    = 1'b1;
          cnt_nxt    = HOLD_LOAD;
          resume_nxt = 1'b0;
          state_nxt  = S_LIVE_HOLD;
        end else if (start) begin
          index_nxt = '0;
          sel_nxt   = ISS_MSG;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        valid_nxt = 1'b1;
        cnt_nxt   = HOLD_LOAD;
        state_nxt = S_HOLD;
        case (iss_sel)
          ISS_LIVE: begin
            out_nxt   = live_char;
            ack_nxt   = 1'b1;
            state_nxt = S_LIVE_HOLD;
          end
`ifdef ANIM_SCHED_BLANK_GAP_EN
          ISS_BLANK: begin
            out_nxt = SEG_BLANK;
            gap_nxt = 1'b1;
          end
`endif
          default: begin
            out_nxt = rd_data;
`ifdef ANIM_SCHED_BLANK_GAP_EN
            gap_nxt = 1'b0;
`endif
          end
        endcase
      end
      S_HOLD: begin
        if (start) begin
          index_nxt = '0;
          sel_nxt   = ISS_MSG;
          state_nxt = S_ISSUE;
`ifdef ANIM_SCHED_BLANK_GAP_EN
          gap_nxt   = 1'b0;
`endif
        end else if (cnt != '0) begin
          cnt_nxt = cnt - 8'd1;
        end else if (live_req) begin
          // index is left alone so the preempted character is reissued later
          out_nxt    = live_char;
          valid_nxt  = 1'b1;
          ack_nxt    = 1'b1;
          cnt_nxt    = HOLD_LOAD;
          resume_nxt = 1'b1;
          state_nxt  = S_LIVE_HOLD;
`ifdef ANIM_SCHED_BLANK_GAP_EN
        end else if (in_gap) begin
          index_nxt = '0;
          gap_nxt   = 1'b0;
          sel_nxt   = ISS_MSG;
          state_nxt = S_ISSUE;
`endif
        end else if (index != msg_last) begin
          // wraps modulo MSG_LEN if msg_last was lowered below index
          index_nxt = index + 1'b1;
          sel_nxt   = ISS_MSG;
          state_nxt = S_ISSUE;
        end else if (loop) begin
`ifdef ANIM_SCHED_BLANK_GAP_EN
          sel_nxt   = ISS_BLANK;
`else
          index_nxt = '0;
          sel_nxt   = ISS_MSG;
`endif
          state_nxt = S_ISSUE;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        if (start) begin
          resume_nxt = 1'b1;
          index_nxt  = '0;
`ifdef ANIM_SCHED_BLANK_GAP_EN
          gap_nxt    = 1'b0;
`endif
        end
        if (cnt != '0) begin
          cnt_nxt = cnt - 8'd1;
        end else if (live_req) begin
          // reissue through ISSUE so live-to-live spacing matches the message period
          sel_nxt   = ISS_LIVE;
          state_nxt = S_ISSUE;
        end else if (resume_nxt) begin
          resume_nxt = 1'b0;
`ifdef ANIM_SCHED_BLANK_GAP_EN
          sel_nxt    = gap_nxt ? ISS_BLANK : ISS_MSG;
`else
          sel_nxt    = ISS_MSG;
`endif
          state_nxt  = S_ISSUE;
        end else begin
          state_nxt = S_IDLE;
        end
      end
    endcase
  end

  // State and registered outputs; enable low freezes everything and masks the pulses.
  always_ff @(posedge clk60 or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      resume     <= 1'b0;
      iss_sel    <= ISS_MSG;
      index      <= '0;
      char_out   <= SEG_BLANK;
      char_valid <= 1'b0;
      live_ack   <= 1'b0;
      busy       <= 1'b0;
`ifdef ANIM_SCHED_BLANK_GAP_EN
      in_gap     <= 1'b0;
`endif
    end else if (enable) begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      resume     <= resume_nxt;
      iss_sel    <= sel_nxt;
      index      <= index_nxt;
      char_out   <= out_nxt;
      char_valid <= valid_nxt;
      live_ack   <= ack_nxt;
      busy       <= (state_nxt != S_IDLE);
`ifdef ANIM_SCHED_BLANK_GAP_EN
      in_gap     <= gap_nxt;
`endif
    end else begin
      char_valid <= 1'b0;
      live_ack   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_anim_char_scheduler.sv
// Self-checking bench for anim_char_scheduler: a scoreboard of expected issues
// (character, ack, tick) checked on every char_valid pulse, plus direct checks.
module tb_anim_char_scheduler;
  import anim_pkg::*;

  localparam int PER = 33;
`ifdef ANIM_SCHED_BLANK_GAP_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 0;
`endif

  logic       clk60 = 1'b0;
  logic       reset, enable, wr_en, start, loop, live_req;
  logic [2:0] wr_addr, msg_last, index;
  logic [6:0] wr_data, live_char, char_out;
  logic       live_ack, char_valid, busy;

  anim_char_scheduler dut (
    .clk60      (clk60),
    .reset      (reset),
    .enable     (enable),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .msg_last   (msg_last),
    .start      (start),
    .loop       (loop),
    .live_req   (live_req),
    .live_char  (live_char),
    .live_ack   (live_ack),
    .char_out   (char_out),
    .char_valid (char_valid),
    .busy       (busy),
    .index      (index)
  );

  always #5 clk60 = ~clk60;

  int tick = 0;
  always @(posedge clk60) tick <= tick + 1;

  typedef struct {
    logic [6:0] ch;
    logic       ack;
    int         t;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [6:0] ch;
    int         len;
    int         n;
  } live_vec_t;
  live_vec_t lv[4];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h (%0d), required 0x%0h (%0d) at tick %0d", nm, act, act, exp, exp, tick);
    end
  endtask

  task automatic push(input logic [6:0] ch, input logic ack, input int t);
    exp_t e;
    e.ch = ch; e.ack = ack; e.t = t;
    sb.push_back(e);
  endtask

  task automatic wait_until(input int t);
    while (tick < t) begin
      @(posedge clk60);
      #1;
    end
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(posedge clk60);
      #1;
      k++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d issues pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [6:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk60);
    #1;
    wr_en = 1'b0;
  endtask

  // Scoreboard: every issue pulse must match the next expected record.
  always @(negedge clk60) begin
    exp_t e;
    if (char_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_issue: got char 0x%0h ack %0b at tick %0d, required no issue", char_out, live_ack, tick);
      end else begin
        e = sb.pop_front();
        chk("issue_char", int'(char_out), int'(e.ch));
        chk("issue_ack", int'(live_ack), int'(e.ack));
        chk("issue_tick", tick, e.t);
      end
    end else if (live_ack !== 1'b0) begin
      n_chk++;
      n_fail++;
      $display("FAIL stray_ack: got live_ack %0b without char_valid at tick %0d, required 0", live_ack, tick);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int T;
    int last;
    lv[0] = '{7'h3F, 70, 3};
    lv[1] = '{7'h06, 1, 1};
    lv[2] = '{7'h5B, 32, 1};
    lv[3] = '{7'h4F, 33, 2};

    reset = 1'b1; enable = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    msg_last = '0; start = 1'b0; loop = 1'b0; live_req = 1'b0; live_char = '0;
    repeat (3) @(posedge clk60);
    #1;
    chk("rst_char_out", int'(char_out), 0);
    chk("rst_char_valid", int'(char_valid), 0);
    chk("rst_live_ack", int'(live_ack), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_index", int'(index), 0);
    reset = 1'b0;
    @(posedge clk60);
    #1;

    wr(3'd0, 7'h06); wr(3'd1, 7'h5B); wr(3'd2, 7'h4F);

    // one-shot message
    msg_last = 3'd2; loop = 1'b0;
    T = tick;
    start = 1'b1;
    push(7'h06, 1'b0, T + 2); push(7'h5B, 1'b0, T + 2 + PER); push(7'h4F, 1'b0, T + 2 + 2 * PER);
    @(posedge clk60);
    #1;
    start = 1'b0;
    wait_until(T + 101);
    drain(10);
    chk("oneshot_busy", int'(busy), 0);
    chk("oneshot_index", int'(index), 2);

    // looping message, loop dropped after the first wrap
    T = tick;
    loop = 1'b1; start = 1'b1;
    push(7'h06, 1'b0, T + 2); push(7'h5B, 1'b0, T + 35); push(7'h4F, 1'b0, T + 68);
    if (GAP != 0) push(SEG_BLANK, 1'b0, T + 101);
    push(7'h06, 1'b0, T + 101 + GAP * PER);
    push(7'h5B, 1'b0, T + 134 + GAP * PER);
    push(7'h4F, 1'b0, T + 167 + GAP * PER);
    @(posedge clk60);
    #1;
    start = 1'b0;
    wait_until(T + 110);
    chk("wrap_index", int'(index), (GAP != 0) ? 2 : 0);
    loop = 1'b0;
    wait_until(T + 200 + GAP * PER);
    drain(10);
    chk("loop_end_busy", int'(busy), 0);
    chk("loop_end_index", int'(index), 2);

    // live preemption at HOLD expiry of index 1
    T = tick;
    start = 1'b1;
    push(7'h06, 1'b0, T + 2); push(7'h5B, 1'b0, T + 35);
    @(posedge clk60);
    #1;
    start = 1'b0;
    wait_until(T + 45);
    chk("preempt_index", int'(index), 1);
    live_char = 7'h3F; live_req = 1'b1;
    push(7'h3F, 1'b1, T + 67); push(7'h5B, 1'b0, T + 100); push(7'h4F, 1'b0, T + 133);
    wait_until(T + 70);
    live_req = 1'b0;
    wait_until(T + 166);
    drain(10);
    chk("preempt_end_busy", int'(busy), 0);
    chk("preempt_end_index", int'(index), 2);

    // live requests from IDLE, table of hold lengths
    for (int i = 0; i < 4; i++) begin
      T = tick;
      live_char = lv[i].ch; live_req = 1'b1;
      for (int k = 0; k < lv[i].n; k++) push(lv[i].ch, 1'b1, T + 1 + PER * k);
      wait_until(T + lv[i].len);
      live_req = 1'b0;
      last = T + 1 + PER * (lv[i].n - 1);
      wait_until(last + 33);
      drain(5);
      chk("live_idle_busy", int'(busy), 0);
    end

    // reset ten ticks into HOLD of index 1
    T = tick;
    start = 1'b1;
    push(7'h06, 1'b0, T + 2); push(7'h5B, 1'b0, T + 35);
    @(posedge clk60);
    #1;
    start = 1'b0;
    wait_until(T + 45);
    chk("prereset_index", int'(index), 1);
    reset = 1'b1;
    #1;
    chk("midrst_char_out", int'(char_out), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_index", int'(index), 0);
    chk("midrst_char_valid", int'(char_valid), 0);
    @(posedge clk60);
    @(posedge clk60);
    #1;
    reset = 1'b0;
    T = tick;
    wait_until(T + 100);
    chk("postrst_busy", int'(busy), 0);
    // buffer must have been cleared: buf[0] now plays as blank
    msg_last = 3'd0;
    T = tick;
    start = 1'b1;
    push(7'h00, 1'b0, T + 2);
    @(posedge clk60);
    #1;
    start = 1'b0;
    wait_until(T + 35);
    drain(5);
    chk("cleared_busy", int'(busy), 0);

    // enable low for 5 ticks spanning the first expiry
    wr(3'd0, 7'h06); wr(3'd1, 7'h5B); wr(3'd2, 7'h4F);
    msg_last = 3'd2;
    T = tick;
    start = 1'b1;
    push(7'h06, 1'b0, T + 2); push(7'h5B, 1'b0, T + 40); push(7'h4F, 1'b0, T + 73);
    @(posedge clk60);
    #1;
    start = 1'b0;
    wait_until(T + 30);
    enable = 1'b0;
    wait_until(T + 33);
    chk("frozen_busy", int'(busy), 1);
    wait_until(T + 35);
    chk("frozen_index", int'(index), 0);
    enable = 1'b1;
    wait_until(T + 106);
    drain(10);
    chk("enable_end_busy", int'(busy), 0);
    chk("enable_end_index", int'(index), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
